// File: rtl/ov2640_dvp_capture.sv
// OV2640 DVP capture: pairs bytes into RGB565 pixels with x/y and frame markers after AEC/AWB skip.
// Optional size/alignment checking and out-of-range pixel suppression under DVP_SIZE_CHECK_EN.
module ov2640_dvp_capture #(
   parameter int unsigned H_ACTIVE    = 800,
   parameter int unsigned V_ACTIVE    = 600,
   parameter int unsigned SKIP_FRAMES = 10,
   parameter bit          VSYNC_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init_ready,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  din,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic        frame_start,
   output logic        frame_end,
   output logic [7:0]  frame_count,
   output logic        size_err
);

`ifdef DVP_SIZE_CHECK_EN
   localparam bit SizeCheck = 1'b1;
`else
   localparam bit SizeCheck = 1'b0;
`endif
   localparam logic [11:0] HMax     = 12'(H_ACTIVE);
   localparam logic [11:0] VMax     = 12'(V_ACTIVE);
   localparam logic [15:0] SkipLast = 16'(SKIP_FRAMES - 1);

   typedef enum logic [1:0] {StWaitInit, StSkip, StSync, StActive} state_e;

   state_e      state_q, state_d;
   logic        vsync_q, href_q, init_q, vs_prev_q;
   logic [7:0]  din_q;
   logic [15:0] skip_q, skip_d;
   logic        phase_q, phase_d;
   logic [7:0]  hi_q, hi_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic [15:0] data_q, data_d;
   logic        valid_q, valid_d, fs_q, fs_d, fe_q, fe_d, err_q, err_d;
   logic [11:0] px_q, px_d, py_q, py_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic        vs_act, vs_rise, vs_fall;

   // vs_act is high during blanking regardless of sensor polarity
   assign vs_act  = VSYNC_POL ? vsync_q : ~vsync_q;
   assign vs_rise = vs_act & ~vs_prev_q;
   assign vs_fall = ~vs_act & vs_prev_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vsync_q   <= 1'b0;
         href_q    <= 1'b0;
         din_q     <= '0;
         init_q    <= 1'b0;
         vs_prev_q <= 1'b0;
         state_q   <= StWaitInit;
         skip_q    <= '0;
         phase_q   <= 1'b0;
         hi_q      <= '0;
         x_q       <= '0;
         y_q       <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         fs_q      <= 1'b0;
         fe_q      <= 1'b0;
         fcnt_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         vsync_q   <= vsync;
         href_q    <= href;
         din_q     <= din;
         init_q    <= init_ready;
         vs_prev_q <= vs_act;
         state_q   <= state_d;
         skip_q    <= skip_d;
         phase_q   <= phase_d;
         hi_q      <= hi_d;
         x_q       <= x_d;
         y_q       <= y_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         px_q      <= px_d;
         py_q      <= py_d;
         fs_q      <= fs_d;
         fe_q      <= fe_d;
         fcnt_q    <= fcnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      phase_d = phase_q;
      hi_d    = hi_q;
      x_d     = x_q;
      y_d     = y_q;
      data_d  = data_q;
      valid_d = 1'b0;
      px_d    = px_q;
      py_d    = py_q;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
      fcnt_d  = fcnt_q;
      err_d   = err_q;
      unique case (state_q)
         StWaitInit: begin
            if (init_q) begin
               skip_d  = '0;
               state_d = (SKIP_FRAMES == 0) ? StSync : StSkip;
            end
         end
         StSkip: begin
            if (vs_rise) begin
               if (skip_q == SkipLast) state_d = StSync;
               else                    skip_d  = skip_q + 16'd1;
            end
         end
         StSync: begin
            if (vs_fall) state_d = StActive;
         end
         StActive: begin
            // vsync wins over a coincident byte
            if (vs_rise) begin
               state_d = StSync;
               fe_d    = 1'b1;
               fcnt_d  = fcnt_q + 8'd1;
               if (SizeCheck && (y_q != VMax)) err_d = 1'b1;
            end else if (href_q) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  hi_d = din_q;
               end else begin
                  valid_d = !SizeCheck || ((x_q < HMax) && (y_q < VMax));
                  if (valid_d) begin
                     data_d = {hi_q, din_q};
                     px_d   = x_q;
                     py_d   = y_q;
                  end
                  fs_d = valid_d && (x_q == '0) && (y_q == '0);
                  if (x_q != '1) x_d = x_q + 12'd1;
               end
            end else if ((x_q != '0) || phase_q) begin
               // href fell: drop any half pixel and close the line
               phase_d = 1'b0;
               x_d     = '0;
               if ((x_q != '0) && (y_q != '1)) y_d = y_q + 12'd1;
               if (SizeCheck && ((x_q != HMax) || phase_q)) err_d = 1'b1;
            end
         end
      endcase
      if (state_q != StActive) begin
         phase_d = 1'b0;
         x_d     = '0;
         y_d     = '0;
      end
      if (!init_ready) begin
         state_d = StWaitInit;
         valid_d = 1'b0;
         fs_d    = 1'b0;
         fe_d    = 1'b0;
         fcnt_d  = fcnt_q;
         err_d   = err_q;
      end
   end

   assign pixel_data  = data_q;
   assign pixel_valid = valid_q;
   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign frame_start = fs_q;
   assign frame_end   = fe_q;
   assign frame_count = fcnt_q;
   assign size_err    = err_q;

endmodule

// File: doc/ov2640_dvp_capture.md
Name: ov2640_dvp_capture

Overview:
- Downstream of the OV2640 SCCB init stage. Captures the camera's 8-bit DVP byte stream (VSYNC/HREF/D[7:0]) once the init stage asserts ready.
- Pairs bytes into RGB565 pixels and emits them with x/y coordinates and frame/line markers to the frame-buffer writer.
- Skips a configurable number of frames after init so auto exposure (AEC) and auto white balance (AWB) can settle.

Parameters:
- H_ACTIVE, 800, expected pixels per line; sets the pixel_x range and the size check.
- V_ACTIVE, 600, expected lines per frame.
- SKIP_FRAMES, 10, complete frames discarded after init_ready rises.
- VSYNC_POL, 1, 1 = vsync high during blanking/sync (OV2640 default); 0 = inverted.

Ports:
- clk  input  1  camera PCLK; all logic sampled on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- init_ready  input  1  init-stage ready; level; capture is enabled only while high.
- vsync  input  1  DVP frame sync.
- href  input  1  DVP line valid; a byte is present on every clk while high.
- din  input  8  DVP data byte.
- pixel_data  output  16  RGB565 pixel; first byte of the pair is [15:8].
- pixel_valid  output  1  one-cycle strobe per pixel.
- pixel_x  output  12  column of pixel_data, 0..H_ACTIVE-1.
- pixel_y  output  12  row of pixel_data, 0..V_ACTIVE-1.
- frame_start  output  1  one-cycle pulse coincident with the first pixel_valid of a frame (x=0, y=0).
- frame_end  output  1  one-cycle pulse on the first vsync assertion after a captured frame.
- frame_count  output  8  completed captured frames; wraps 255 -> 0.
- size_err  output  1  sticky size/alignment error; cleared only by reset.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all outputs 0, state WAIT_INIT, counters 0.
  - reset mid-frame discards any partial pixel and line immediately.
- Input handling:
  - vsync is normalised by VSYNC_POL into vs_act, active = blanking.
  - vsync, href and din are registered once before use, giving 1 cycle of input latency.
- State machine:
  - WAIT_INIT: idle; go to SKIP when the registered init_ready is 1.
  - SKIP: count vs_act rising edges. After SKIP_FRAMES edges, go to SYNC. SKIP_FRAMES=0 goes straight to SYNC.
  - SYNC: wait for a vs_act falling edge (start of active frame), then go to ACTIVE with y=0.
  - ACTIVE: capture bytes while href=1. On a vs_act rising edge: pulse frame_end, increment frame_count, return to SYNC.
  - Any state: init_ready=0 returns to WAIT_INIT next cycle. No frame_end is pulsed and frame_count is unchanged.
- Byte pairing:
  - A phase bit toggles on each href=1 cycle and clears when href=0.
  - Phase 0: latch the high byte.
  - Phase 1: output {hi, din} with pixel_valid=1 on the following cycle. Total latency from the second byte at the pins to pixel_valid is 2 clks.
- Coordinates:
  - pixel_x increments after each pixel and resets to 0 on the href falling edge.
  - pixel_y increments on each href falling edge that followed at least one pixel.
  - x saturates at 4095 and y at 4095; there is no wrap.
- Odd byte count: if href falls with phase=1, the half byte is dropped and size_err is set (when checking is enabled).
- frame_start: asserted with pixel (0,0) only; a frame with no pixels produces no frame_start.
- Simultaneous href=1 and vs_act rising edge: vs_act wins. The byte is ignored and frame_end fires.

Optional Feature:
- Macro DVP_SIZE_CHECK_EN.
- Defined:
  - size_err is set if a line ends with pixel_x != H_ACTIVE.
  - size_err is set if a frame ends with line count != V_ACTIVE.
  - size_err is set on an odd byte count.
  - Pixels beyond H_ACTIVE/V_ACTIVE are suppressed: no pixel_valid.
- Undefined: size_err is tied to 0; all pixels are passed through and only the coordinate saturation applies.

Test Plan:
- reset_n=0 for 3 clks with init_ready=1 and traffic running -> all outputs 0; no pixel_valid until SKIP_FRAMES+1 vsync cycles have passed after release.
- SKIP_FRAMES=2, H_ACTIVE=4, V_ACTIVE=2; bytes 0x12,0x34,0x56,0x78 on line 0 ->
  - pixel_valid with 0x1234 (x=0, y=0, frame_start=1), then 0x5678 (x=1), each 2 clks after its second byte.
  - After a full frame: frame_end pulse, frame_count=1.
- init_ready dropped mid-line -> no further pixel_valid; frame_count held. After init_ready returns: 2 frames are skipped again before capture.
- Line of 7 bytes with DVP_SIZE_CHECK_EN -> 3 pixels out, size_err=1 and stays 1 until reset. Without the macro -> 3 pixels out, size_err=0.
- Line of 6 pixels with H_ACTIVE=4 and the macro defined -> only x=0..3 emitted, size_err=1.
- 256 captured frames -> frame_count wraps to 0; VSYNC_POL=0 with an inverted vsync stream -> identical pixel output.
